sobel_writeback: RTL and testbench

SOBEL_WRITEBACK -- requirements
Module: sobel_writeback

---
 rtl/sobel_writeback_if.sv | 30 +++
 rtl/sobel_writeback.sv | 115 +++++++++++
 tb/tb_sobel_writeback.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_writeback_if.sv
// Pixel-stream, memory-write and control signals of the Sobel writeback stage.
// The master is the image source plus memory; the slave is the writeback block.
interface sobel_writeback_if #(
  parameter int PIX_BITS = 8,
  parameter int PACK     = 4
);
  logic                     start;
  logic [11:0]              width;
  logic [11:0]              length;
  logic [7:0]               initial_addr_w;
  logic                     pix_valid;
  logic [PIX_BITS-1:0]      pix_data;
  logic                     pix_ready;
  logic                     mem_wen;
  logic [15:0]              mem_addr;
  logic [PIX_BITS*PACK-1:0] mem_wdata;
  logic                     mem_ack;
  logic                     busy;
  logic                     done;

  modport master (
    output start, width, length, initial_addr_w, pix_valid, pix_data, mem_ack,
    input  pix_ready, mem_wen, mem_addr, mem_wdata, busy, done
  );

  modport slave (
    input  start, width, length, initial_addr_w, pix_valid, pix_data, mem_ack,
    output pix_ready, mem_wen, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/sobel_writeback.sv
// Packs Sobel edge-magnitude pixels into memory words and writes one image
// to consecutive word addresses starting at a latched base.
module sobel_writeback #(
  parameter int PIX_BITS = 8,
  parameter int PACK     = 4
) (
  input logic             clk,
  input logic             n_rst,
  sobel_writeback_if.slave bus
);
  localparam int WORD_BITS = PIX_BITS * PACK;
  localparam int LANE_W    = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic [23:0]           total;
  logic [23:0]           pix_count;
  logic [7:0]            base;
  logic [15:0]           word_index;
  logic [WORD_BITS-1:0]  pack_buf;
  logic [LANE_W-1:0]     lane;
  logic [23:0]           area;
  logic                  xfer;
  logic                  word_full;

  assign area      = {12'd0, bus.width} * {12'd0, bus.length};
  assign xfer      = (state == ACCEPT) && bus.pix_valid;
  assign word_full = (lane == LANE_W'(PACK - 1)) || ((pix_count + 24'd1) == total);

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (area == 24'd0) ? DONE : ACCEPT;
        end
      end
      ACCEPT: begin
        if (xfer && word_full) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          state_next = (pix_count == total) ? DONE : ACCEPT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The pack buffer is cleared after every acknowledged write so that the
  // unused lanes of a trailing partial word read back as zero.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      total      <= '0;
      pix_count  <= '0;
      base       <= '0;
      word_index <= '0;
      pack_buf   <= '0;
      lane       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            total      <= area;
            base       <= bus.initial_addr_w;
            pix_count  <= '0;
            word_index <= '0;
            pack_buf   <= '0;
            lane       <= '0;
          end
        end
        ACCEPT: begin
          if (xfer) begin
            pack_buf[lane*PIX_BITS +: PIX_BITS] <= bus.pix_data;
            pix_count                           <= pix_count + 24'd1;
            lane                                <= lane + 1'b1;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            word_index <= word_index + 16'd1;
            pack_buf   <= '0;
            lane       <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.pix_ready = (state == ACCEPT);
  assign bus.mem_wen   = (state == WRITE);
  assign bus.mem_addr  = (state == WRITE) ? ({8'd0, base} + word_index) : 16'd0;
  assign bus.mem_wdata = (state == WRITE) ? pack_buf : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_sobel_writeback.sv
// Randomized and directed bench for sobel_writeback; expected memory words are
// built from the pixel list by plain packing arithmetic.
module tb_sobel_writeback;
  localparam int PIX_BITS = 8;
  localparam int PACK     = 4;
  localparam int WB       = PIX_BITS * PACK;

  logic clk;
  logic n_rst;
  int   compared;
  int   mismatched;
  logic [7:0]    fixed_pix[$];
  logic [15:0]   last_addr;
  logic [WB-1:0] last_data;
  int            last_writes;

  sobel_writeback_if #(.PIX_BITS(PIX_BITS), .PACK(PACK)) bus ();

  sobel_writeback #(.PIX_BITS(PIX_BITS), .PACK(PACK)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic apply_stimulus(input int w, input int l, input logic [7:0] base);
    @(negedge clk);
    bus.start          = 1'b1;
    bus.width          = 12'(w);
    bus.length         = 12'(l);
    bus.initial_addr_w = base;
    @(negedge clk);
    bus.start          = 1'b0;
    bus.width          = 12'($urandom);
    bus.length         = 12'($urandom);
    bus.initial_addr_w = 8'($urandom);
  endtask

  task automatic run_image(input int w, input int l, input logic [7:0] base,
                           input int min_delay, input int max_delay,
                           input int restart_at, input string tag);
    int            total;
    int            words;
    logic [7:0]    pix[$];
    logic [WB-1:0] exp_data[$];
    logic [WB-1:0] d;
    logic [15:0]   hold_addr;
    logic [WB-1:0] hold_data;
    int            idx;
    int            wcount;
    int            done_cnt;
    int            done_cyc;
    int            cyc;
    int            delay;
    int            wait_cnt;
    bit            in_wait;
    bit            saw_ready;

    total = w * l;
    words = (total + PACK - 1) / PACK;
    if (fixed_pix.size() > 0) pix = fixed_pix;
    else for (int i = 0; i < total; i++) pix.push_back(8'($urandom));
    for (int wi = 0; wi < words; wi++) begin
      d = '0;
      for (int k = 0; k < PACK; k++)
        if (wi * PACK + k < total) d = d | (WB'(pix[wi*PACK+k]) << (PIX_BITS * k));
      exp_data.push_back(d);
    end

    idx = 0; wcount = 0; done_cnt = 0; done_cyc = -1; cyc = 0;
    in_wait = 0; saw_ready = 0; delay = 0; wait_cnt = 0;
    hold_addr = '0; hold_data = '0;
    apply_stimulus(w, l, base);

    while (cyc < 3000) begin
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        break;
      end
      if (bus.pix_ready) saw_ready = 1;
      if (bus.mem_wen) begin
        check_output({tag, "_ready_in_write"}, 64'(bus.pix_ready), 64'd0);
        if (!in_wait) begin
          in_wait   = 1;
          hold_addr = bus.mem_addr;
          hold_data = bus.mem_wdata;
          delay     = $urandom_range(max_delay, min_delay);
          wait_cnt  = 0;
        end else begin
          check_output({tag, "_addr_hold"}, 64'(bus.mem_addr), 64'(hold_addr));
          check_output({tag, "_data_hold"}, 64'(bus.mem_wdata), 64'(hold_data));
        end
        if (wait_cnt == delay) begin
          bus.mem_ack = 1'b1;
          check_output({tag, "_addr"}, 64'(bus.mem_addr), 64'({8'd0, base} + 16'(wcount)));
          check_output({tag, "_data"}, 64'(bus.mem_wdata),
                       (wcount < words) ? 64'(exp_data[wcount]) : 64'hDEAD_BEEF_DEAD_BEEF);
          last_addr = bus.mem_addr;
          last_data = bus.mem_wdata;
          wcount++;
          in_wait = 0;
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.mem_ack = 1'($urandom_range(0, 1));
      end

      if (idx < total) begin
        bus.pix_valid = ($urandom_range(0, 3) != 0);
        bus.pix_data  = pix[idx];
      end else begin
        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'($urandom);
      end

      if (cyc == restart_at) begin
        bus.start  = 1'b1;
        bus.width  = 12'(w + 3);
        bus.length = 12'(l + 2);
      end else begin
        bus.start = 1'b0;
      end

      if (bus.pix_valid && bus.pix_ready) idx++;
      @(negedge clk);
      cyc++;
    end

    bus.mem_ack   = 1'b0;
    bus.pix_valid = 1'b0;
    bus.start     = 1'b0;
    last_writes   = wcount;
    check_output({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
    check_output({tag, "_busy_in_done"}, 64'(bus.busy), 64'd1);
    check_output({tag, "_word_count"}, 64'(wcount), 64'(words));
    check_output({tag, "_pix_count"}, 64'(idx), 64'(total));
    if (total == 0) begin
      check_output({tag, "_no_ready"}, 64'(saw_ready), 64'd0);
      check_output({tag, "_done_latency_ok"}, 64'(done_cyc >= 0 && done_cyc <= 1), 64'd1);
    end
    @(negedge clk);
    check_output({tag, "_done_pulse_end"}, 64'(bus.done), 64'd0);
    check_output({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    bus.start = 1'b0; bus.width = '0; bus.length = '0; bus.initial_addr_w = '0;
    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.mem_ack = 1'b0;
    n_rst = 1'b1;
    #12;
    check_output("rst_ready", 64'(bus.pix_ready), 64'd0);
    check_output("rst_wen", 64'(bus.mem_wen), 64'd0);
    check_output("rst_busy", 64'(bus.busy), 64'd0);
    check_output("rst_done", 64'(bus.done), 64'd0);
    check_output("rst_addr", 64'(bus.mem_addr), 64'd0);
    check_output("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    @(negedge clk);
    n_rst = 1'b0;

    fixed_pix = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_image(2, 2, 8'h10, 0, 0, -1, "img2x2");
    check_output("img2x2_writes", 64'(last_writes), 64'd1);
    check_output("img2x2_addr_val", 64'(last_addr), 64'h0010);
    check_output("img2x2_data_val", 64'(last_data), 64'h44332211);

    fixed_pix = '{8'hA1, 8'hA2, 8'hA3};
    run_image(3, 1, 8'h00, 0, 1, -1, "img3x1");
    check_output("img3x1_data_val", 64'(last_data), 64'h00A3A2A1);
    fixed_pix.delete();

    run_image(0, 200, 8'h20, 0, 0, -1, "empty");

    run_image(8, 1, 8'hFF, 3, 3, -1, "wrap");
    check_output("wrap_writes", 64'(last_writes), 64'd2);
    check_output("wrap_last_addr", 64'(last_addr), 64'h0100);

    run_image(5, 2, 8'h40, 0, 2, 3, "restart");

    for (int t = 0; t < 6; t++)
      run_image($urandom_range(1, 9), $urandom_range(1, 3), 8'($urandom), 0, 2, -1, "rand");

    apply_stimulus(8, 1, 8'h30);
    for (int i = 0; i < 200 && !bus.mem_wen; i++) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.pix_valid = 1'b0;
    check_output("midrst_reached_write", 64'(bus.mem_wen), 64'd1);
    #2 n_rst = 1'b1;
    #1;
    check_output("midrst_wen", 64'(bus.mem_wen), 64'd0);
    check_output("midrst_addr", 64'(bus.mem_addr), 64'd0);
    check_output("midrst_wdata", 64'(bus.mem_wdata), 64'd0);
    check_output("midrst_busy", 64'(bus.busy), 64'd0);
    check_output("midrst_ready", 64'(bus.pix_ready), 64'd0);
    check_output("midrst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    check_output("postrst_idle_wen", 64'(bus.mem_wen), 64'd0);
    check_output("postrst_idle_busy", 64'(bus.busy), 64'd0);

    run_image(1, 1, 8'h77, 0, 1, -1, "after_rst");
    check_output("after_rst_addr_val", 64'(last_addr), 64'h0077);
    check_output("after_rst_upper_zero", 64'(last_data[WB-1:PIX_BITS]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
